// File: rtl/dcache_plru.sv
// Tree pseudo-LRU replacement state for a set-associative data cache, with flush sweep.
// Optional build macro DCACHE_PLRU_LOCK_EN adds lock_mask_i to steer victims away from locked ways.
module dcache_plru #(
    parameter int WAYS    = 4,
    parameter int WAY_SEL = 2,
    parameter int SET_SEL = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    output logic               busy_o,
    input  logic               rd_hit_vld_i,
    input  logic [WAY_SEL-1:0] rd_hit_way_i,
    input  logic [SET_SEL-1:0] rd_hit_set_i,
    input  logic               wr_hit_vld_i,
    input  logic [WAY_SEL-1:0] wr_hit_way_i,
    input  logic [SET_SEL-1:0] wr_hit_set_i,
    input  logic               rpl_req_i,
    input  logic [SET_SEL-1:0] rpl_set_i,
`ifdef DCACHE_PLRU_LOCK_EN
    input  logic [WAYS-1:0]    lock_mask_i,
`endif
    output logic               rpl_vld_o,
    output logic [WAY_SEL-1:0] rpl_way_o,
    output logic [WAYS-1:0]    rpl_onehot_o
);

    localparam int SETS  = 2 ** SET_SEL;
    localparam int NODES = WAYS - 1;

    typedef enum logic {IDLE, SWEEP} state_e;

    typedef struct packed {
        logic [WAY_SEL-1:0] way;
        logic [WAYS-1:0]    onehot;
    } victim_t;

    state_e             state_q;
    logic [SET_SEL-1:0] cnt_q;
    logic               busy_q;
    logic               rpl_vld_q;
    logic [WAY_SEL-1:0] rpl_way_q;
    logic [WAYS-1:0]    rpl_onehot_q;
    logic [NODES-1:0]   tree_q [SETS];
    logic [NODES-1:0]   tree_d [SETS];
    logic [WAYS-1:0]    lock_mask;
    victim_t            victim;

`ifdef DCACHE_PLRU_LOCK_EN
    assign lock_mask = lock_mask_i;
`else
    assign lock_mask = '0;
`endif

    // Point every node on way w's root-to-leaf path away from w.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t,
                                               input logic [WAY_SEL-1:0] w);
        logic [NODES-1:0] r;
        logic             b;
        int               n;
        r = t;
        n = 0;
        for (int l = 0; l < WAY_SEL; l++) begin
            b = w[WAY_SEL-1-l];
            for (int k = 0; k < NODES; k++) begin
                if (k == n) r[k] = ~b;
            end
            n = 2 * n + (b ? 2 : 1);
        end
        return r;
    endfunction

    function automatic victim_t pick(input logic [NODES-1:0] t,
                                     input logic [WAYS-1:0]  lock);
        victim_t v;
        logic    b, lo_lk, hi_lk;
        int      n, base, size, half;
        v    = '0;
        n    = 0;
        base = 0;
        size = WAYS;
        for (int l = 0; l < WAY_SEL; l++) begin
            half  = size / 2;
            lo_lk = 1'b1;
            hi_lk = 1'b1;
            for (int i = 0; i < WAYS; i++) begin
                if (i >= base && i < base + half && !lock[i]) lo_lk = 1'b0;
                if (i >= base + half && i < base + size && !lock[i]) hi_lk = 1'b0;
            end
            b = 1'b0;
            for (int k = 0; k < NODES; k++) begin
                if (k == n) b = t[k];
            end
            // A fully locked subtree is never entered while its sibling still has a free way.
            if (!b && lo_lk) b = 1'b1;
            else if (b && hi_lk) b = 1'b0;
            v.way[WAY_SEL-1-l] = b;
            if (b) base = base + half;
            n    = 2 * n + (b ? 2 : 1);
            size = half;
        end
        v.onehot[v.way] = 1'b1;
        if (&lock) v = '0;
        return v;
    endfunction

    // NOTE: tree_d starts as a full copy of tree_q so every path assigns it, which keeps this block latch-free.
    always_comb begin
        tree_d = tree_q;
        if (state_q == SWEEP) begin
            tree_d[cnt_q] = '0;
        end else if (!flush_i) begin
            // Store is applied after load so it wins on shared path nodes.
            if (rd_hit_vld_i) tree_d[rd_hit_set_i] = touch(tree_d[rd_hit_set_i], rd_hit_way_i);
            if (wr_hit_vld_i) tree_d[wr_hit_set_i] = touch(tree_d[wr_hit_set_i], wr_hit_way_i);
        end
    end

    always_comb victim = pick(tree_q[rpl_set_i], lock_mask);

    // NOTE: the table is built from flops rather than RAM because reset must clear every set at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            rpl_vld_q    <= 1'b0;
            rpl_way_q    <= '0;
            rpl_onehot_q <= WAYS'(1);
        end else begin
            rpl_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rpl_req_i) begin
                        rpl_vld_q    <= 1'b1;
                        rpl_way_q    <= victim.way;
                        rpl_onehot_q <= victim.onehot;
                    end
                    if (flush_i) begin
                        state_q <= SWEEP;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                SWEEP: begin
                    cnt_q <= cnt_q + SET_SEL'(1);
                    if (cnt_q == {SET_SEL{1'b1}}) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign rpl_vld_o    = rpl_vld_q;
    assign rpl_way_o    = rpl_way_q;
    assign rpl_onehot_o = rpl_onehot_q;

endmodule

// File: tb/tb_dcache_plru.sv
// Directed-vector bench for dcache_plru (WAYS=4, SET_SEL=7); lock cases build only with DCACHE_PLRU_LOCK_EN.
module tb_dcache_plru;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       busy_o;
    logic       rd_hit_vld_i = 1'b0;
    logic [1:0] rd_hit_way_i = '0;
    logic [6:0] rd_hit_set_i = '0;
    logic       wr_hit_vld_i = 1'b0;
    logic [1:0] wr_hit_way_i = '0;
    logic [6:0] wr_hit_set_i = '0;
    logic       rpl_req_i = 1'b0;
    logic [6:0] rpl_set_i = '0;
`ifdef DCACHE_PLRU_LOCK_EN
    logic [3:0] lock_mask_i = '0;
`endif
    logic       rpl_vld_o;
    logic [1:0] rpl_way_o;
    logic [3:0] rpl_onehot_o;

    int vectors = 0;
    int errors  = 0;

    dcache_plru #(.WAYS(4), .WAY_SEL(2), .SET_SEL(7)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .busy_o       (busy_o),
        .rd_hit_vld_i (rd_hit_vld_i),
        .rd_hit_way_i (rd_hit_way_i),
        .rd_hit_set_i (rd_hit_set_i),
        .wr_hit_vld_i (wr_hit_vld_i),
        .wr_hit_way_i (wr_hit_way_i),
        .wr_hit_set_i (wr_hit_set_i),
        .rpl_req_i    (rpl_req_i),
        .rpl_set_i    (rpl_set_i),
`ifdef DCACHE_PLRU_LOCK_EN
        .lock_mask_i  (lock_mask_i),
`endif
        .rpl_vld_o    (rpl_vld_o),
        .rpl_way_o    (rpl_way_o),
        .rpl_onehot_o (rpl_onehot_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic hit(input logic rv, input logic [6:0] rs, input logic [1:0] rw,
                       input logic wv, input logic [6:0] ws, input logic [1:0] ww);
        rd_hit_vld_i = rv; rd_hit_set_i = rs; rd_hit_way_i = rw;
        wr_hit_vld_i = wv; wr_hit_set_i = ws; wr_hit_way_i = ww;
        step();
        rd_hit_vld_i = 1'b0;
        wr_hit_vld_i = 1'b0;
    endtask

    task automatic query(input string tag, input logic [6:0] s, input logic [1:0] w, input logic [3:0] oh);
        rpl_req_i = 1'b1;
        rpl_set_i = s;
        step();
        rpl_req_i = 1'b0;
        check({tag, " vld"}, rpl_vld_o, 1);
        check({tag, " way"}, rpl_way_o, w);
        check({tag, " onehot"}, rpl_onehot_o, oh);
        step();
        check({tag, " vld drop"}, rpl_vld_o, 0);
        check({tag, " way hold"}, rpl_way_o, w);
    endtask

    initial begin
        int  busy_cnt;
        bit  vld_seen;

        #23;
        check("reset busy", busy_o, 0);
        check("reset vld", rpl_vld_o, 0);
        check("reset way", rpl_way_o, 0);
        check("reset onehot", rpl_onehot_o, 4'b0001);
        step();
        rst_i = 1'b1;
        step();

        query("fresh s5", 7'd5, 2'd0, 4'b0001);

        // Load way 0 -> victim 2; store way 2 -> victim 1.
        hit(1, 7'd5, 2'd0, 0, 7'd0, 2'd0);
        query("s5 after ld w0", 7'd5, 2'd2, 4'b0100);
        hit(0, 7'd0, 2'd0, 1, 7'd5, 2'd2);
        query("s5 after st w2", 7'd5, 2'd1, 4'b0010);

        hit(1, 7'd3, 2'd0, 1, 7'd3, 2'd1);
        query("s3 same-set", 7'd3, 2'd2, 4'b0100);

        hit(1, 7'd11, 2'd0, 0, 7'd0, 2'd0);
        hit(1, 7'd10, 2'd1, 1, 7'd11, 2'd2);
        query("s10 diff-set", 7'd10, 2'd2, 4'b0100);
        query("s11 diff-set", 7'd11, 2'd1, 4'b0010);

        // Query and hit on the same set in one cycle: victim sees the old state.
        rpl_req_i = 1'b1; rpl_set_i = 7'd20;
        hit(1, 7'd20, 2'd0, 0, 7'd0, 2'd0);
        rpl_req_i = 1'b0;
        check("s20 pre-update way", rpl_way_o, 0);
        step();
        query("s20 post-update", 7'd20, 2'd2, 4'b0100);

        rpl_req_i = 1'b1;
        rpl_set_i = 7'd5;  step(); check("b2b s5", rpl_way_o, 1); check("b2b s5 vld", rpl_vld_o, 1);
        rpl_set_i = 7'd3;  step(); check("b2b s3", rpl_way_o, 2); check("b2b s3 vld", rpl_vld_o, 1);
        rpl_set_i = 7'd11; step(); check("b2b s11", rpl_way_o, 1); check("b2b s11 vld", rpl_vld_o, 1);
        rpl_req_i = 1'b0;
        step();
        check("b2b end vld", rpl_vld_o, 0);

        hit(1, 7'd0, 2'd0, 1, 7'd127, 2'd0);
        query("primed s0", 7'd0, 2'd2, 4'b0100);
        query("primed s127", 7'd127, 2'd2, 4'b0100);

        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        busy_cnt = 0;
        vld_seen = 1'b0;
        rd_hit_vld_i = 1'b1; rd_hit_set_i = 7'd0;   rd_hit_way_i = 2'd0;
        wr_hit_vld_i = 1'b1; wr_hit_set_i = 7'd127; wr_hit_way_i = 2'd0;
        rpl_req_i = 1'b1; rpl_set_i = 7'd0;
        for (int c = 0; c < 300; c++) begin
            if (!busy_o) break;
            busy_cnt++;
            if (rpl_vld_o) vld_seen = 1'b1;
            flush_i = (busy_cnt == 60);
            step();
        end
        flush_i = 1'b0;
        rd_hit_vld_i = 1'b0;
        wr_hit_vld_i = 1'b0;
        rpl_req_i = 1'b0;
        check("sweep busy cycles", busy_cnt, 128);
        check("sweep vld seen", vld_seen, 0);
        step();
        check("sweep done busy", busy_o, 0);
        query("flushed s0", 7'd0, 2'd0, 4'b0001);
        query("flushed s127", 7'd127, 2'd0, 4'b0001);
        query("flushed s5", 7'd5, 2'd0, 4'b0001);

        hit(1, 7'd9, 2'd0, 1, 7'd100, 2'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int c = 0; c < 40; c++) step();
        check("mid-sweep busy", busy_o, 1);
        rst_i = 1'b0;
        #1;
        check("async rst busy", busy_o, 0);
        check("async rst onehot", rpl_onehot_o, 4'b0001);
        step();
        rst_i = 1'b1;
        step();
        check("post rst busy", busy_o, 0);
        query("post rst s9", 7'd9, 2'd0, 4'b0001);
        query("post rst s100", 7'd100, 2'd0, 4'b0001);
        hit(1, 7'd9, 2'd0, 0, 7'd0, 2'd0);
        query("post rst idle hit", 7'd9, 2'd2, 4'b0100);

`ifdef DCACHE_PLRU_LOCK_EN
        hit(1, 7'd5, 2'd1, 0, 7'd0, 2'd0);
        query("lock none", 7'd5, 2'd2, 4'b0100);
        lock_mask_i = 4'b1100;
        query("lock 1100", 7'd5, 2'd0, 4'b0001);
        lock_mask_i = 4'b0100;
        query("lock 0100", 7'd5, 2'd3, 4'b1000);
        lock_mask_i = 4'b1111;
        query("lock all", 7'd5, 2'd0, 4'b0000);
        lock_mask_i = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dcache_plru.md
DCACHE_PLRU -- requirements
Module: dcache_plru

Interface
REQ-001 Parameter WAYS, default 4, associativity; power of two, 2..16.
REQ-002 Parameter WAY_SEL, default 2, equals log2(WAYS).
REQ-003 Parameter SET_SEL, default 7, set index width; SETS = 2**SET_SEL.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_i  in  1  asynchronous reset, active-low.
REQ-006 flush_i  in  1  one-cycle request to clear the whole PLRU table.
REQ-007 busy_o  out  1  high while a flush sweep is running.
REQ-008 rd_hit_vld_i / rd_hit_way_i / rd_hit_set_i  in  1 / WAY_SEL / SET_SEL  load-port hit: valid, way, set.
REQ-009 wr_hit_vld_i / wr_hit_way_i / wr_hit_set_i  in  1 / WAY_SEL / SET_SEL  store-port hit: valid, way, set.
REQ-010 rpl_req_i / rpl_set_i  in  1 / SET_SEL  victim query: valid, set.
REQ-011 rpl_vld_o / rpl_way_o / rpl_onehot_o  out  1 / WAY_SEL / WAYS  victim result: valid, binary way, one-hot way.
REQ-012 lock_mask_i  in  WAYS  per-way lock, bit i = way i excluded from victim choice; present only with DCACHE_PLRU_LOCK_EN.

Function
REQ-013 Each set holds WAYS-1 tree bits, heap-ordered: node 0 root, children of node n are 2n+1 (lower ways) and 2n+2 (upper ways).
REQ-014 Node bit 0 = victim lies in lower-way subtree; 1 = upper-way subtree.
REQ-015 A valid hit on way w sets every node on w's path to point away from w; off-path nodes unchanged; update visible the next cycle.
REQ-016 Hits on different sets in one cycle update both sets independently.
REQ-017 Hits on the same set in one cycle: nodes on the store path take the store direction, remaining load-path nodes take the load direction (store becomes MRU).
REQ-018 Victim walk starts at root, follows node bits to a leaf; the leaf gives rpl_way_o and rpl_onehot_o.
REQ-019 Victim uses table contents before same-cycle hit updates; rpl_vld_o and the way outputs are registered, valid one cycle after rpl_req_i, rpl_vld_o high for exactly one cycle per request.
REQ-020 Back-to-back rpl_req_i every cycle yields one result per cycle, in order.
REQ-021 rpl_way_o/rpl_onehot_o hold their last value while rpl_vld_o is low.
REQ-022 FSM states IDLE, SWEEP; flush_i in IDLE -> SWEEP next cycle, busy_o high.
REQ-023 SWEEP clears one set per cycle from set 0 to SETS-1 via SET_SEL-bit counter; after clearing set SETS-1 -> IDLE, busy_o low; busy_o high exactly SETS cycles.
REQ-024 During SWEEP: flush_i ignored, hit updates dropped, rpl_req_i ignored (rpl_vld_o stays 0).
REQ-025 flush_i together with hits in IDLE: flush wins, hits dropped.

Reset
REQ-026 rst_i low asynchronously clears all tree bits, FSM to IDLE, counter to 0, busy_o=0, rpl_vld_o=0, rpl_way_o=0, rpl_onehot_o=1.
REQ-027 Reset mid-sweep aborts the sweep; after release block is IDLE with table fully cleared.

Configuration
REQ-028 Macro DCACHE_PLRU_LOCK_EN defined: lock_mask_i exists; at each node, if the chosen subtree is fully locked the other subtree is taken; all ways locked -> rpl_vld_o still pulses, rpl_onehot_o=0, rpl_way_o=0.
REQ-029 Macro undefined: lock_mask_i absent, plain tree walk, rpl_onehot_o always one-hot.
REQ-030 Hit updates are identical with and without the macro (locked ways still update LRU state).

Verification (WAYS=4, SET_SEL=7)
REQ-031 Reset, rpl_req_i set 5 -> next cycle rpl_vld_o=1, rpl_way_o=0, rpl_onehot_o=4'b0001.
REQ-032 Load hit set 5 way 0, then query set 5 -> rpl_way_o=2; then store hit set 5 way 2, query -> rpl_way_o=1.
REQ-033 Same cycle load hit set 3 way 0 and store hit set 3 way 1 -> nodes {0,1,2}={1,0,0}, query set 3 -> rpl_way_o=2.
REQ-034 Prime sets 0 and 127, flush_i -> busy_o high 128 cycles, hits/queries ignored throughout, afterwards queries return way 0.
REQ-035 Macro on, set 5 state pointing at way 2, lock_mask_i=4'b1100 -> rpl_way_o=0; lock_mask_i=4'b1111 -> rpl_vld_o=1, rpl_onehot_o=0.
REQ-036 Assert rst_i low at sweep cycle 40 -> busy_o=0 immediately, all queries after release return way 0.
